// File: rtl/rt_stage_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rt_arb_pkg
// Purpose  : Shared types and constants for the rt_stage_arbiter slice.
//            - arb_state_t : arbiter FSM states (IDLE, BUSY, HOLD)
//            - LATENCY_MIN : smallest supported stage latency
//            - tag_w()     : width of a requester index for n requesters
// Revision : 1.0 - initial release
// ============================================================================
package rt_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_HOLD = 2'd2
   } arb_state_t;

   localparam int LATENCY_MIN = 2;

   // Requester index width; never narrower than one bit.
   function automatic int tag_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rt_stage_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rt_stage_arbiter_if
// Purpose  : Handshake bundle between requesters/consumer and the arbiter.
// Ports    : req_valid/req_ready  per-requester job handshake
//            unit_start/unit_sel  shared-stage launch pulse and operand select
//            rsp_valid/rsp_tag/rsp_ready  tagged result handshake
//            busy                 arbiter owns an in-flight job
// Modports : master - requester/consumer side, slave - arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface rt_stage_arbiter_if
   import rt_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = tag_w(NUM_REQ)
);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   logic               unit_start;
   logic [TAG_W-1:0]   unit_sel;
   logic               rsp_valid;
   logic [TAG_W-1:0]   rsp_tag;
   logic               rsp_ready;
   logic               busy;

   modport master (
      output req_valid, rsp_ready,
      input  req_ready, unit_start, unit_sel, rsp_valid, rsp_tag, busy
   );

   modport slave (
      input  req_valid, rsp_ready,
      output req_ready, unit_start, unit_sel, rsp_valid, rsp_tag, busy
   );
endinterface
`default_nettype wire

// File: rtl/rt_stage_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Selects the first set bit of
//            req at or after ptr, wrapping modulo NUM_REQ.
// Ports    : req     - request vector
//            ptr     - highest-priority index
//            gnt     - one-hot winner (zero when no request)
//            gnt_idx - binary winner index
//            any     - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 2
) (
   input  wire logic [NUM_REQ-1:0] req,
   input  wire logic [TAG_W-1:0]   ptr,
   output logic      [NUM_REQ-1:0] gnt,
   output logic      [TAG_W-1:0]   gnt_idx,
   output logic                    any
);

   // Each requester's distance from ptr (going upward with wrap) is its
   // priority rank; the smallest rank among active requests wins.
   always_comb begin
      int w_best;
      int w_win;
      int w_dist;
      w_best  = NUM_REQ;
      w_win   = 0;
      w_dist  = 0;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_dist = j - int'(ptr);
         if (w_dist < 0) w_dist = w_dist + NUM_REQ;
         if (req[j] && (w_dist < w_best)) begin
            w_best = w_dist;
            w_win  = j;
         end
      end
      if (w_best < NUM_REQ) begin
         any     = 1'b1;
         gnt     = NUM_REQ'(1) << w_win;
         gnt_idx = TAG_W'(w_win);
      end
   end

endmodule
`default_nettype wire

// File: rtl/rt_stage_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rt_stage_arbiter
// Purpose  : Round-robin controller sharing one fixed-latency, non-pipelined
//            compute stage between NUM_REQ requesters. Grants one job,
//            launches the stage, counts LATENCY cycles, then holds the
//            tagged result until the consumer accepts it.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - rt_stage_arbiter_if.slave (request, stage, response)
// Options  : RT_STAGE_ARB_BACK_TO_BACK_EN - allow a new grant in the same
//            cycle a held result is accepted (one job per LATENCY cycles).
// Revision : 1.0 - initial release
// ============================================================================
module rt_stage_arbiter
   import rt_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 7,
   parameter int CNT_W   = $clog2(LATENCY),
   parameter int TAG_W   = $clog2(NUM_REQ)
) (
   input wire logic          clk,
   input wire logic          rst_n,
   rt_stage_arbiter_if.slave bus
);

   localparam logic [1:0]       c_S_IDLE   = 2'(ARB_IDLE);
   localparam logic [1:0]       c_S_BUSY   = 2'(ARB_BUSY);
   localparam logic [1:0]       c_S_HOLD   = 2'(ARB_HOLD);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LATENCY - 2);
   localparam logic [TAG_W-1:0] c_TAG_TOP  = TAG_W'(NUM_REQ - 1);

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_count;
   logic [TAG_W-1:0]   r_ptr;
   logic [TAG_W-1:0]   r_tag;

   logic [NUM_REQ-1:0] w_gnt;
   logic [TAG_W-1:0]   w_gnt_idx;
   logic               w_any;
   logic               w_arb_en;
   logic               w_grant;
   logic [TAG_W-1:0]   w_ptr_next;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .TAG_W   (TAG_W)
   ) u_pick (
      .req     (bus.req_valid),
      .ptr     (r_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .any     (w_any)
   );

   // Arbitration window. Qualified by rst_n so the combinational grant path
   // stays quiet while reset is held with requests pending.
   always_comb begin
`ifdef RT_STAGE_ARB_BACK_TO_BACK_EN
      w_arb_en = rst_n && ((r_state == c_S_IDLE) ||
                           ((r_state == c_S_HOLD) && bus.rsp_ready));
`else
      w_arb_en = rst_n && (r_state == c_S_IDLE);
`endif
      w_grant    = w_arb_en && w_any;
      w_ptr_next = (w_gnt_idx == c_TAG_TOP) ? '0 : w_gnt_idx + TAG_W'(1);
   end

   // unit_sel shows the winner already in the grant cycle; rsp_tag only
   // moves to the new owner once the grant has been registered.
   always_comb begin
      bus.req_ready  = w_arb_en ? w_gnt : '0;
      bus.unit_start = w_grant;
      bus.unit_sel   = w_grant ? w_gnt_idx : r_tag;
      bus.rsp_valid  = (r_state == c_S_HOLD);
      bus.rsp_tag    = r_tag;
      bus.busy       = (r_state != c_S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_S_IDLE;
         r_count <= '0;
         r_ptr   <= '0;
         r_tag   <= '0;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (w_grant) begin
                  r_tag   <= w_gnt_idx;
                  r_ptr   <= w_ptr_next;
                  r_count <= '0;
                  r_state <= c_S_BUSY;
               end
            end
            c_S_BUSY: begin
               // Final increment lands on LATENCY-1 as HOLD is entered.
               r_count <= r_count + CNT_W'(1);
               if (r_count == c_CNT_LAST) r_state <= c_S_HOLD;
            end
            c_S_HOLD: begin
               if (bus.rsp_ready) begin
                  if (w_grant) begin
                     r_tag   <= w_gnt_idx;
                     r_ptr   <= w_ptr_next;
                     r_count <= '0;
                     r_state <= c_S_BUSY;
                  end else begin
                     r_state <= c_S_IDLE;
                  end
               end
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rt_stage_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rt_stage_arbiter
// Purpose  : Self-checking bench for rt_stage_arbiter (NUM_REQ=4, LATENCY=7).
//            A job-level reference model (owner, launch cycle, pointer)
//            predicts every output each cycle; directed scenarios add
//            hand-computed expectations, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rt_stage_arbiter;

   localparam int N   = 4;
   localparam int LAT = 7;
`ifdef RT_STAGE_ARB_BACK_TO_BACK_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif

   logic clk;
   logic rst_n;

   rt_stage_arbiter_if #(.NUM_REQ(N), .TAG_W(2)) bus ();

   rt_stage_arbiter #(
      .NUM_REQ (N),
      .LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: a job is active from the cycle after its grant until
   // its result is accepted; the result is visible LAT cycles after grant.
   bit m_active = 1'b0;
   int m_tag    = 0;
   int m_start  = 0;
   int m_ptr    = 0;

   logic [N-1:0] s_ready;
   logic         s_start;
   logic [1:0]   s_sel;
   logic         s_valid;
   logic [1:0]   s_tag;
   logic         s_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic step(input logic [N-1:0] req, input logic rr, input logic rv);
      bit hold, arb_en, found;
      int w, idx;
      logic [N-1:0] e_ready;
      @(negedge clk);
      rst_n         = rv;
      bus.req_valid = req;
      bus.rsp_ready = rr;
      #1;
      s_ready = bus.req_ready;
      s_start = bus.unit_start;
      s_sel   = bus.unit_sel;
      s_valid = bus.rsp_valid;
      s_tag   = bus.rsp_tag;
      s_busy  = bus.busy;
      if (!rv) begin
         m_active = 1'b0;
         m_ptr    = 0;
         m_tag    = 0;
         chk("m_rst_ready", 32'(s_ready), 0);
         chk("m_rst_start", 32'(s_start), 0);
         chk("m_rst_sel",   32'(s_sel),   0);
         chk("m_rst_valid", 32'(s_valid), 0);
         chk("m_rst_tag",   32'(s_tag),   0);
         chk("m_rst_busy",  32'(s_busy),  0);
      end else begin
         hold   = m_active && ((cyc - m_start) >= LAT);
         arb_en = !m_active || (BTB && hold && rr);
         found  = 1'b0;
         w      = 0;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && (((req >> idx) & 1) != 0)) begin
               found = 1'b1;
               w     = idx;
            end
         end
         e_ready = (arb_en && found) ? N'(1 << w) : '0;
         chk("m_req_ready",  32'(s_ready), 32'(e_ready));
         chk("m_unit_start", 32'(s_start), 32'(arb_en && found));
         chk("m_unit_sel",   32'(s_sel),   32'((arb_en && found) ? w : m_tag));
         chk("m_rsp_valid",  32'(s_valid), 32'(hold));
         chk("m_rsp_tag",    32'(s_tag),   32'(m_tag));
         chk("m_busy",       32'(s_busy),  32'(m_active));
         if (hold && rr) m_active = 1'b0;
         if (arb_en && found) begin
            m_active = 1'b1;
            m_tag    = w;
            m_start  = cyc;
            m_ptr    = (w + 1) % N;
         end
      end
      cyc++;
   endtask

   task automatic wait_grant(input logic [N-1:0] req, input logic rr, input int bound,
                             output int n);
      n = 0;
      do begin
         step(req, rr, 1'b1);
         n++;
      end while (!s_start && n < bound);
      if (!s_start) chk("grant_timeout", 0, 1);
   endtask

   task automatic drain();
      repeat (10) step('0, 1'b1, 1'b1);
   endtask

   initial begin
      int n;
      int t0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;

      // Reset state
      step(4'b1111, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      chk("rst_ready", 32'(s_ready), 0);
      chk("rst_start", 32'(s_start), 0);
      chk("rst_sel",   32'(s_sel),   0);
      chk("rst_valid", 32'(s_valid), 0);
      chk("rst_tag",   32'(s_tag),   0);
      chk("rst_busy",  32'(s_busy),  0);

      // Single request from requester 2
      step(4'b0100, 1'b1, 1'b1);
      chk("single_ready", 32'(s_ready), 32'h4);
      chk("single_start", 32'(s_start), 1);
      chk("single_sel",   32'(s_sel),   2);
      t0 = 0;
      for (int i = 1; i < LAT; i++) begin
         step('0, 1'b1, 1'b1);
         if (s_valid) t0++;
      end
      chk("single_early_valid", 32'(t0), 0);
      step('0, 1'b1, 1'b1);
      chk("single_valid", 32'(s_valid), 1);
      chk("single_tag",   32'(s_tag),   2);

      // Pointer wrap: grant 3, then 1001 must go to 0
      wait_grant(4'b1000, 1'b1, 20, n);
      chk("wrap_pre", 32'(s_ready), 32'h8);
      wait_grant(4'b1001, 1'b1, 20, n);
      chk("wrap_ready", 32'(s_ready), 32'h1);
      drain();

      // All four held continuously
      step('0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         wait_grant(4'b1111, 1'b1, 20, n);
         chk("rr_order", 32'(s_sel), 32'(i % 4));
         if (i > 0) chk("rr_spacing", 32'(n), BTB ? 32'd7 : 32'd8);
      end
      drain();

      // Backpressure on a job from requester 1
      wait_grant(4'b0010, 1'b0, 20, n);
      chk("bp_grant", 32'(s_ready), 32'h2);
      n = 0;
      do begin
         step('0, 1'b0, 1'b1);
         n++;
      end while (!s_valid && n < 20);
      chk("bp_valid_rise", 32'(n), 32'(LAT));
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b0, 1'b1);
         chk("bp_valid", 32'(s_valid), 1);
         chk("bp_tag",   32'(s_tag),   1);
         chk("bp_sel",   32'(s_sel),   1);
         chk("bp_start", 32'(s_start), 0);
      end
      step(4'b1111, 1'b1, 1'b1);
      drain();

      // Reset in the middle of a job
      wait_grant(4'b0100, 1'b1, 20, n);
      repeat (2) step('0, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b0);
      chk("mid_rst_ready", 32'(s_ready), 0);
      chk("mid_rst_start", 32'(s_start), 0);
      chk("mid_rst_valid", 32'(s_valid), 0);
      chk("mid_rst_busy",  32'(s_busy),  0);
      chk("mid_rst_tag",   32'(s_tag),   0);
      step(4'b1111, 1'b1, 1'b0);
      step(4'b1111, 1'b1, 1'b1);
      chk("mid_rst_first", 32'(s_ready), 32'h1);
      drain();

      // Sparse requests from ptr=0
      step('0, 1'b1, 1'b0);
      step(4'b1010, 1'b1, 1'b1);
      chk("sparse_ready", 32'(s_ready), 32'h2);
      chk("sparse_start", 32'(s_start), 1);
      repeat (LAT + 1) step('0, 1'b1, 1'b1);
      wait_grant(4'b1010, 1'b1, 20, n);
      chk("sparse_ptr", 32'(s_ready), 32'h8);
      drain();

      // Randomized traffic with occasional reset
      repeat (3000) begin
         step(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 599) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
